// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between an instruction-fetch
// port (read-only) and a load/store port, with a watchdog for accesses that never ack.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_ack,
  output logic                  i_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ack,
  output logic                  d_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);

  logic [1:0]           state;
  logic                 lastGrant;
  logic [CNT_WIDTH-1:0] watchdog;

  logic                 grantD;
  logic [CNT_WIDTH-1:0] watchdogNext;
  logic                 timedOut;

  // NOTE: every signal is assigned unconditionally here, so no latch can be inferred.
  always_comb begin
    // On a conflict the port that did not win last time gets the memory.
    grantD       = d_req && (!i_req || (lastGrant == GRANT_I));
    watchdogNext = (watchdog == {CNT_WIDTH{1'b1}}) ? watchdog : watchdog + 1'b1;
    timedOut     = (TIMEOUT != 0) && (watchdogNext == TIMEOUT_CNT);
  end

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: reset is synchronous; an in-flight access is dropped without an ack.
      state     <= IDLE;
      lastGrant <= GRANT_I;
      watchdog  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ack     <= 1'b0;
      i_err     <= 1'b0;
      i_rdata   <= '0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            mem_req   <= 1'b1;
            watchdog  <= '0;
            lastGrant <= grantD ? GRANT_D : GRANT_I;
            if (grantD) begin
              state     <= BUSY_D;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              state     <= BUSY_I;
              mem_we    <= 1'b0;
              mem_addr  <= i_addr;
              mem_wdata <= '0;
            end
          end
        end

        BUSY_I, BUSY_D: begin
          // A real ack on the final watchdog cycle still wins over the timeout.
          if (mem_ack || timedOut) begin
            state   <= RESP;
            mem_req <= 1'b0;
            if (state == BUSY_I) begin
              i_ack   <= 1'b1;
              i_err   <= !mem_ack;
              i_rdata <= mem_ack ? mem_rdata : '0;
            end else begin
              d_ack   <= 1'b1;
              d_err   <= !mem_ack;
              d_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
            end
          end else begin
            watchdog <= watchdogNext;
          end
        end

        RESP: begin
          state   <= IDLE;
          i_ack   <= 1'b0;
          i_err   <= 1'b0;
          i_rdata <= '0;
          d_ack   <= 1'b0;
          d_err   <= 1'b0;
          d_rdata <= '0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected memory accesses and acks
// into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          i_ack, i_err, d_ack, d_err;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy;

  mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          isD;
    logic [DW-1:0] rdata;
    logic          err;
    int            cyc;
  } ackExpT;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            len;
  } memExpT;

  ackExpT ackQ[$];
  memExpT memQ[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int dAckCount = 0;

  // Memory model knobs.
  int            memWait = 0;
  logic [DW-1:0] memData = '0;
  logic          memAckEn = 1'b1;
  logic          strayAck = 1'b0;
  int            memCnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitAck(input logic isD, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(isD ? d_ack : i_ack) && n < budget);
    if (!(isD ? d_ack : i_ack)) check(isD ? "d_ack_wait" : "i_ack_wait", 32'd0, 32'd1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: acks after memWait cycles of mem_req, or injects a stray ack.
  always @(negedge clk) begin
    if (mem_req) begin
      mem_ack   = memAckEn && (memCnt == memWait);
      mem_rdata = mem_ack ? memData : '0;
      memCnt++;
    end else begin
      memCnt    = 0;
      mem_ack   = strayAck;
      mem_rdata = strayAck ? 32'hFFFF_FFFF : '0;
    end
  end

  // Monitor / scoreboard.
  logic   memReqPrev = 1'b0;
  int     memLen = 0;
  memExpT curMem;
  ackExpT e;

  always @(negedge clk) begin
    if (i_ack || d_ack) begin
      check("ack_exclusive", {31'd0, i_ack & d_ack}, 32'd0);
      if (ackQ.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = ackQ.pop_front();
        check("ack_port", {31'd0, d_ack}, {31'd0, e.isD});
        check("ack_rdata", d_ack ? d_rdata : i_rdata, e.rdata);
        check("ack_err", {31'd0, d_ack ? d_err : i_err}, {31'd0, e.err});
        check("ack_cycle", cyc, e.cyc);
      end
      if (d_ack) dAckCount++;
    end
    if (mem_req) begin
      if (!memReqPrev) begin
        memLen = 0;
        if (memQ.size() == 0) begin
          check("unexpected_mem_req", 32'd1, 32'd0);
          curMem = '{1'bx, 'x, 'x, -1};
        end else begin
          curMem = memQ.pop_front();
        end
      end
      memLen++;
      check("mem_we", {31'd0, mem_we}, {31'd0, curMem.we});
      check("mem_addr", mem_addr, curMem.addr);
      check("mem_wdata", mem_wdata, curMem.wdata);
    end else if (memReqPrev) begin
      check("mem_req_len", memLen, curMem.len);
    end
    memReqPrev = mem_req;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  int c;
  int base;

  initial begin
    rst_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_i_ack", {31'd0, i_ack}, 32'd0);
    check("rst_d_ack", {31'd0, d_ack}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_rdata", i_rdata | d_rdata, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single zero-wait instruction read
    memData = 32'h2402_0005; memWait = 0;
    i_req = 1'b1; i_addr = 32'h0000_0040;
    memQ.push_back(memExpT'{1'b0, 32'h40, 32'h0, 1});
    ackQ.push_back(ackExpT'{1'b0, 32'h2402_0005, 1'b0, cyc + 2});
    waitAck(1'b0, 20);
    tick();
    i_req = 1'b0; i_addr = '0;
    tick();

    // Data write with three wait cycles; read data must come back as zero
    memData = 32'hBAD0_BAD0; memWait = 3;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000_0000; d_wdata = 32'hDEAD_BEEF;
    memQ.push_back(memExpT'{1'b1, 32'h1000_0000, 32'hDEAD_BEEF, 4});
    ackQ.push_back(ackExpT'{1'b1, 32'h0, 1'b0, cyc + 5});
    waitAck(1'b1, 20);
    tick();
    d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    tick();

    // Reset in the middle of a BUSY_D access
    memAckEn = 1'b0;
    base = dAckCount;
    d_req = 1'b1; d_addr = 32'h0000_2000;
    memQ.push_back(memExpT'{1'b0, 32'h2000, 32'h0, 2});
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    d_req = 1'b0;
    tick();
    rst_n = 1'b1; memAckEn = 1'b1; memWait = 0;
    repeat (3) tick();
    check("rst_mid_no_d_ack", dAckCount, base);

    // Continuous conflict: D first after reset, then strict alternation
    memData = 32'h0BAD_F00D;
    i_req = 1'b1; i_addr = 32'h0000_0100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200; d_wdata = 32'h5A5A_5A5A;
    c = cyc;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        memQ.push_back(memExpT'{1'b0, 32'h200, 32'h5A5A_5A5A, 1});
        ackQ.push_back(ackExpT'{1'b1, 32'h0BAD_F00D, 1'b0, c + 2 + 3 * k});
      end else begin
        memQ.push_back(memExpT'{1'b0, 32'h100, 32'h0, 1});
        ackQ.push_back(ackExpT'{1'b0, 32'h0BAD_F00D, 1'b0, c + 2 + 3 * k});
      end
    end
    repeat (12) tick();
    i_req = 1'b0; d_req = 1'b0; d_wdata = '0;
    repeat (2) tick();

    // Watchdog timeout on a data read that never acks
    memAckEn = 1'b0; memData = 32'hFFFF_FFFF;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
    memQ.push_back(memExpT'{1'b0, 32'h300, 32'h0, 4});
    ackQ.push_back(ackExpT'{1'b1, 32'h0, 1'b1, cyc + 5});
    waitAck(1'b1, 30);
    tick();
    d_req = 1'b0;

    // Stray mem_ack while idle must be ignored
    strayAck = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stray_busy", {31'd0, busy}, 32'd0);
      check("stray_mem_req", {31'd0, mem_req}, 32'd0);
    end
    strayAck = 1'b0; memAckEn = 1'b1; memWait = 0;
    tick();

    // Back-to-back fetch: req held through ack, next address presented in RESP
    memData = 32'h0000_1111;
    i_req = 1'b1; i_addr = 32'h0000_0040;
    memQ.push_back(memExpT'{1'b0, 32'h40, 32'h0, 1});
    ackQ.push_back(ackExpT'{1'b0, 32'h0000_1111, 1'b0, cyc + 2});
    waitAck(1'b0, 20);
    i_addr = 32'h0000_0044; memData = 32'h0000_2222;
    memQ.push_back(memExpT'{1'b0, 32'h44, 32'h0, 1});
    ackQ.push_back(ackExpT'{1'b0, 32'h0000_2222, 1'b0, cyc + 3});
    waitAck(1'b0, 20);
    tick();
    i_req = 1'b0;
    repeat (3) tick();

    check("ack_queue_drained", ackQ.size(), 32'd0);
    check("mem_queue_drained", memQ.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
